// File: rtl/popcount_stream.sv
`default_nettype none
// ============================================================================
// Module      : popcount_stream
// Description : Handshaked ones/zeros counter. Counts one CHUNK_W slice of a
//               DATA_W word per cycle and keeps a saturating running total
//               across a group of words closed by a last flag.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_stream #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = $clog2(DATA_W + 1),
  parameter int ACC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [ACC_W-1:0]  out_total,
  output logic              out_sat
);

  localparam int NCH   = DATA_W / CHUNK_W;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  // One spare bit over the wider operand so the accumulator sum never wraps
  localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] word_q;     // shifts right one chunk per BUSY cycle
  logic              last_q;
  logic [CNT_W-1:0]  partial;
  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;
  logic              sat;        // internal sticky flag, cleared at group end

  logic [CNT_W-1:0]  chunk_ones;
  logic [CNT_W-1:0]  partial_next;
  logic [SUM_W-1:0]  acc_sum;
  logic              clip;
  logic [ACC_W-1:0]  acc_next;
  logic              last_chunk;

  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);

  // Popcount of the chunk currently sitting in the low bits of the word
  always_comb begin
    chunk_ones = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      chunk_ones = chunk_ones + CNT_W'(word_q[i]);
    end
  end

  // Next partial count and clipped running total for the final chunk
  always_comb begin
    partial_next = partial + chunk_ones;
    acc_sum      = SUM_W'(acc) + SUM_W'(partial_next);
    clip         = (acc_sum > SUM_W'({ACC_W{1'b1}}));
    acc_next     = clip ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    last_chunk   = (idx == IDX_W'(NCH - 1));
  end

  // Control FSM, datapath registers and held outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_q    <= '0;
      last_q    <= 1'b0;
      partial   <= '0;
      idx       <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      out_count <= '0;
      out_total <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Zero counting is done by counting ones of the inverted word
            word_q  <= in_mode ? ~in_data : in_data;
            last_q  <= in_last;
            partial <= '0;
            idx     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          partial <= partial_next;
          word_q  <= word_q >> CHUNK_W;
          idx     <= idx + IDX_W'(1);
          if (last_chunk) begin
            out_count <= partial_next;
            acc       <= acc_next;
            out_total <= acc_next;
            sat       <= sat | clip;
            out_sat   <= sat | clip;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            // Group closes: clear internal state, displayed values stay
            if (last_q) begin
              acc <= '0;
              sat <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_popcount_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_stream
// Description : Self-checking bench for popcount_stream. Two instances
//               (ACC_W=16 and ACC_W=8) driven by directed and random words,
//               compared against a plain arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Instance A: ACC_W=16
  logic        a_in_valid, a_in_mode, a_in_last, a_out_ready;
  logic [31:0] a_in_data;
  logic        a_in_ready, a_out_valid, a_out_sat;
  logic [5:0]  a_out_count;
  logic [15:0] a_out_total;

  // Instance B: ACC_W=8
  logic        b_in_valid, b_in_mode, b_in_last, b_out_ready;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_out_valid, b_out_sat;
  logic [5:0]  b_out_count;
  logic [7:0]  b_out_total;

  popcount_stream #(.DATA_W(32), .CHUNK_W(8), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_count(a_out_count), .out_total(a_out_total), .out_sat(a_out_sat)
  );

  popcount_stream #(.DATA_W(32), .CHUNK_W(8), .ACC_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_count(b_out_count), .out_total(b_out_total), .out_sat(b_out_sat)
  );

  // Observation mux: sel picks which instance the current step targets
  bit          sel = 1'b0;
  logic        o_in_ready, o_out_valid, o_out_sat;
  logic [5:0]  o_out_count;
  logic [15:0] o_out_total;
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_out_sat   = sel ? b_out_sat   : a_out_sat;
  assign o_out_count = sel ? b_out_count : a_out_count;
  assign o_out_total = sel ? {8'd0, b_out_total} : a_out_total;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: group total and sticky flag per instance
  int unsigned m_acc [2] = '{0, 0};
  bit          m_sat [2] = '{0, 0};
  int unsigned m_max [2] = '{65535, 255};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input bit s, input logic v, input logic [31:0] d,
                       input logic m, input logic l);
    if (s) begin
      b_in_valid = v; b_in_data = d; b_in_mode = m; b_in_last = l;
    end else begin
      a_in_valid = v; a_in_data = d; a_in_mode = m; a_in_last = l;
    end
  endtask

  task automatic set_ordy(input bit s, input logic r);
    if (s) b_out_ready = r;
    else   a_out_ready = r;
  endtask

  // One full word transaction with optional output back-pressure
  task automatic xfer(input bit s, input logic [31:0] data, input logic mode,
                      input logic last, input int hold);
    int unsigned cnt, exp_total;
    bit          exp_sat;
    int          lat;
    logic [5:0]  held_cnt;
    logic [15:0] held_tot;
    logic        held_sat;
    sel       = s;
    cnt       = $countones(mode ? ~data : data);
    exp_total = m_acc[s] + cnt;
    exp_sat   = m_sat[s];
    if (exp_total > m_max[s]) begin
      exp_total = m_max[s];
      exp_sat   = 1'b1;
    end
    @(negedge clk);
    drive(s, 1'b1, data, mode, last);
    lat = 0;
    while (!o_in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("accept_ready", 32'(o_in_ready), 32'd1);
    @(posedge clk);
    #1 drive(s, 1'b0, $urandom, 1'($urandom), 1'($urandom));
    // While busy, in_valid/in_data/in_mode churn must have no effect
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (o_out_valid) break;
      lat++;
      drive(s, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    end
    check("latency", 32'(lat), 32'd4);
    check("count", 32'(o_out_count), cnt);
    check("total", 32'(o_out_total), exp_total);
    check("sat", 32'(o_out_sat), 32'(exp_sat));
    held_cnt = o_out_count;
    held_tot = o_out_total;
    held_sat = o_out_sat;
    for (int h = 0; h < hold; h++) begin
      drive(s, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      @(negedge clk);
      check("hold_outputs", {o_out_valid, o_in_ready, o_out_sat, o_out_count, o_out_total},
            {1'b1, 1'b0, held_sat, held_cnt, held_tot});
    end
    drive(s, 1'b0, 32'd0, 1'b0, 1'b0);
    set_ordy(s, 1'b1);
    @(posedge clk);
    #1 set_ordy(s, 1'b0);
    m_acc[s] = last ? 0 : exp_total;
    m_sat[s] = last ? 1'b0 : exp_sat;
    @(negedge clk);
    check("idle_after", {o_in_ready, o_out_valid}, 32'b10);
  endtask

  initial begin
    bit any_valid;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);

    // Reset state
    #12;
    check("rst_outputs", {a_in_ready, a_out_valid, a_out_sat, a_out_count, a_out_total}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rst", 32'(a_in_ready), 32'd1);

    // Directed words
    xfer(1'b0, 32'hF0F000FF, 1'b0, 1'b1, 0);   // 16 ones
    xfer(1'b0, 32'h00000001, 1'b1, 1'b1, 0);   // 31 zeros
    xfer(1'b0, 32'h00000000, 1'b1, 1'b1, 0);   // 32 zeros, full width
    xfer(1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    xfer(1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    xfer(1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 0);
    xfer(1'b0, 32'h00000003, 1'b0, 1'b1, 0);   // group cleared
    xfer(1'b0, 32'h0000FFFF, 1'b0, 1'b0, 6);   // back-pressure in DONE

    // Reset pulsed mid-BUSY discards the word and the group total
    sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midbusy_rst", {a_in_ready, a_out_valid, a_out_sat, a_out_count, a_out_total}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc[0] = 0; m_sat[0] = 1'b0;
    m_acc[1] = 0; m_sat[1] = 1'b0;
    #1 check("ready_after_pulse", 32'(a_in_ready), 32'd1);
    any_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_valid |= a_out_valid;
    end
    check("no_lost_output", 32'(any_valid), 32'd0);
    xfer(1'b0, 32'h00000003, 1'b0, 1'b1, 0);

    // Random words against the model
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 2)));
    end

    // Saturation on the 8-bit accumulator instance
    for (int i = 0; i < 8; i++) xfer(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    xfer(1'b1, 32'h00000001, 1'b0, 1'b1, 0);
    xfer(1'b1, 32'h00000001, 1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      xfer(1'b1, $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
